// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle core controller: FSM states, opcodes
// and the datapath select codes the controller drives.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        RST      = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECR    = 4'd7,
        EXECI    = 4'd8,
        ALUWB    = 4'd9,
        JAL      = 4'd10,
        BRANCH   = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_JAL) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/instr_dec_imm.sv
// Opcode to immediate-format decoder; purely combinational and independent
// of the controller state.
module instr_dec_imm
    import core_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] imm_src_o
);

    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_LW, OP_I: imm_src_o = IMM_I;
            OP_SW:       imm_src_o = IMM_S;
            OP_BR:       imm_src_o = IMM_B;
            OP_JAL:      imm_src_o = IMM_J;
            default:     imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences each instruction, drives datapath
// selects/enables and counts retired instructions.
module main_fsm
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       Op,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    input  logic             Mem_Ready,
    output logic             Pc_Write,
    output logic             Adr_Src,
    output logic             Mem_Write,
    output logic             Ir_Write,
    output logic [1:0]       Result_Src,
    output logic [1:0]       Alu_Src_A,
    output logic [1:0]       Alu_Src_B,
    output logic             Reg_Write,
    output logic [1:0]       Alu_Op,
    output logic [1:0]       Imm_Src,
    output logic             Illegal_Instr,
    output logic [CNT_W-1:0] Instr_Count,
    output logic [3:0]       Dbg_State
);

    // Memory handshake: an access (FETCH, MEMREAD, MEMWRITE) holds its state
    // and its request outputs until a cycle with Mem_Ready = 1, which both
    // completes the access and advances the FSM on the next edge.

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             unused_funct3;

    assign unused_funct3 = ^Funct3[2:1];

    instr_dec_imm u_dec_imm (
        .op_i      (Op),
        .imm_src_o (Imm_Src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            RST:      state_d = FETCH;
            FETCH:    if (Mem_Ready) state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BR:        state_d = BRANCH;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = Op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (Mem_Ready) state_d = MEMWB;
            MEMWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEMWRITE: begin
                if (Mem_Ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            JAL:      state_d = ALUWB;
            ALUWB, BRANCH: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default:  state_d = FETCH;
        endcase
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        Pc_Write      = 1'b0;
        Adr_Src       = 1'b0;
        Mem_Write     = 1'b0;
        Ir_Write      = 1'b0;
        Result_Src    = RES_ALUOUT;
        Alu_Src_A     = SRCA_PC;
        Alu_Src_B     = SRCB_RD2;
        Reg_Write     = 1'b0;
        Alu_Op        = ALU_ADD;
        Illegal_Instr = 1'b0;
        case (state_q)
            FETCH: begin
                Alu_Src_B  = SRCB_FOUR;
                Result_Src = RES_ALURES;
                Ir_Write   = Mem_Ready;
                Pc_Write   = Mem_Ready;
            end
            DECODE: begin
                Alu_Src_A     = SRCA_OLDPC;
                Alu_Src_B     = SRCB_IMM;
                Illegal_Instr = !op_supported(Op);
            end
            MEMADR: begin
                Alu_Src_A = SRCA_RD1;
                Alu_Src_B = SRCB_IMM;
            end
            MEMREAD:  Adr_Src = 1'b1;
            MEMWB: begin
                Result_Src = RES_DATA;
                Reg_Write  = 1'b1;
            end
            MEMWRITE: begin
                Adr_Src   = 1'b1;
                Mem_Write = 1'b1;
            end
            EXECR: begin
                Alu_Src_A = SRCA_RD1;
                Alu_Op    = ALU_FUNCT;
            end
            EXECI: begin
                Alu_Src_A = SRCA_RD1;
                Alu_Src_B = SRCB_IMM;
                Alu_Op    = ALU_FUNCT;
            end
            JAL: begin
                Alu_Src_A = SRCA_OLDPC;
                Alu_Src_B = SRCB_FOUR;
                Pc_Write  = 1'b1;
            end
            ALUWB:    Reg_Write = 1'b1;
            BRANCH: begin
                // beq takes on Zero, bne (Funct3[0] = 1) on !Zero
                Alu_Src_A = SRCA_RD1;
                Alu_Op    = ALU_SUB;
                Pc_Write  = Zero ^ Funct3[0];
            end
            default: ;
        endcase
    end

    assign Instr_Count = cnt_q;
    assign Dbg_State   = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed-vector bench for main_fsm with a per-cycle expected-output
// scoreboard; a narrow counter is used so wrap-around is reachable.
module tb_main_fsm;

    localparam int CW = 3;
    localparam int W  = 16 + 4 + CW;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] LW_OP  = 7'b0000011;
    localparam logic [6:0] SW_OP  = 7'b0100011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] BAD_OP = 7'b1111111;

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
        S_MEMADR = 4'd3, S_MEMREAD = 4'd4, S_MEMWB = 4'd5, S_MEMWRITE = 4'd6,
        S_EXECR = 4'd7, S_EXECI = 4'd8, S_ALUWB = 4'd9, S_JAL = 4'd10,
        S_BRANCH = 4'd11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    Op = R_OP;
    logic [2:0]    Funct3 = 3'b000;
    logic          Zero = 1'b0;
    logic          Mem_Ready = 1'b0;
    logic          Pc_Write, Adr_Src, Mem_Write, Ir_Write, Reg_Write, Illegal_Instr;
    logic [1:0]    Result_Src, Alu_Src_A, Alu_Src_B, Alu_Op, Imm_Src;
    logic [CW-1:0] Instr_Count;
    logic [3:0]    Dbg_State;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    main_fsm #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Op            (Op),
        .Funct3        (Funct3),
        .Zero          (Zero),
        .Mem_Ready     (Mem_Ready),
        .Pc_Write      (Pc_Write),
        .Adr_Src       (Adr_Src),
        .Mem_Write     (Mem_Write),
        .Ir_Write      (Ir_Write),
        .Result_Src    (Result_Src),
        .Alu_Src_A     (Alu_Src_A),
        .Alu_Src_B     (Alu_Src_B),
        .Reg_Write     (Reg_Write),
        .Alu_Op        (Alu_Op),
        .Imm_Src       (Imm_Src),
        .Illegal_Instr (Illegal_Instr),
        .Instr_Count   (Instr_Count),
        .Dbg_State     (Dbg_State)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

    // Output pack: {pc,adr,mw,ir,rs[2],sa[2],sb[2],rw,aop[2],imm[2],ill}
    function automatic logic [15:0] o(input logic pc, input logic adr, input logic mw,
                                      input logic ir, input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic rw, input logic [1:0] aop,
                                      input logic [1:0] imm, input logic ill);
        return {pc, adr, mw, ir, rs, sa, sb, rw, aop, imm, ill};
    endfunction

    function automatic logic [15:0] o_fetch(input logic mr, input logic [1:0] imm);
        return o(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, imm, 1'b0);
    endfunction

    function automatic logic [15:0] o_dec(input logic [1:0] imm, input logic ill);
        return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, imm, ill);
    endfunction

    // driver: apply inputs for the current cycle, queue the expected outputs
    task automatic push_exp(input string name, input logic [3:0] st,
                            input logic [15:0] outs, input logic [CW-1:0] cnt);
        exp_q.push_back({outs, st, cnt});
        name_q.push_back(name);
    endtask

    task automatic step(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic z, input logic mr, input logic [3:0] st,
                        input logic [15:0] outs, input logic [CW-1:0] cnt);
        Op        = op;
        Funct3    = f3;
        Zero      = z;
        Mem_Ready = mr;
        push_exp(name, st, outs, cnt);
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] act, expv;
        string        nm;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                nm   = name_q.pop_front();
                act  = {Pc_Write, Adr_Src, Mem_Write, Ir_Write, Result_Src, Alu_Src_A,
                        Alu_Src_B, Reg_Write, Alu_Op, Imm_Src, Illegal_Instr,
                        Dbg_State, Instr_Count};
                n_checks++;
                if (act !== expv) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
                end
            end
        end
    end

    typedef struct packed {
        logic [2:0] f3;
        logic       z;
        logic       pc;
    } br_vec_t;

    initial begin
        br_vec_t br_tab[3];
        logic [CW-1:0] cnt;
        br_tab[0] = '{f3: 3'b000, z: 1'b1, pc: 1'b1};
        br_tab[1] = '{f3: 3'b000, z: 1'b0, pc: 1'b0};
        br_tab[2] = '{f3: 3'b001, z: 1'b0, pc: 1'b1};

        @(posedge clk);
        #1;
        step("rst_hold", R_OP, 3'b000, 1'b0, 1'b1, S_RST, 16'h0000, 3'd0);
        rst_n = 1'b1;
        step("rst_release", R_OP, 3'b000, 1'b0, 1'b1, S_RST, 16'h0000, 3'd0);

        // R-type
        step("r_fetch", R_OP, 3'b000, 1'b0, 1'b1, S_FETCH, o_fetch(1'b1, 2'b00), 3'd0);
        step("r_decode", R_OP, 3'b000, 1'b0, 1'b1, S_DECODE, o_dec(2'b00, 1'b0), 3'd0);
        step("r_execr", R_OP, 3'b000, 1'b0, 1'b1, S_EXECR,
             o(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 2'b00, 0), 3'd0);
        step("r_aluwb", R_OP, 3'b000, 1'b0, 1'b1, S_ALUWB,
             o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0), 3'd0);

        // lw with three wait cycles in MEMREAD
        step("lw_fetch", LW_OP, 3'b000, 1'b0, 1'b1, S_FETCH, o_fetch(1'b1, 2'b00), 3'd1);
        step("lw_decode", LW_OP, 3'b000, 1'b0, 1'b1, S_DECODE, o_dec(2'b00, 1'b0), 3'd1);
        step("lw_memadr", LW_OP, 3'b000, 1'b0, 1'b1, S_MEMADR,
             o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'b00, 0), 3'd1);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("lw_memread%0d", i), LW_OP, 3'b000, 1'b0, (i == 3), S_MEMREAD,
                 o(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0), 3'd1);
        end
        step("lw_memwb", LW_OP, 3'b000, 1'b0, 1'b1, S_MEMWB,
             o(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0), 3'd1);

        // sw with a fetch stall and one write wait cycle
        step("sw_fetch_stall", SW_OP, 3'b000, 1'b0, 1'b0, S_FETCH, o_fetch(1'b0, 2'b01), 3'd2);
        step("sw_fetch", SW_OP, 3'b000, 1'b0, 1'b1, S_FETCH, o_fetch(1'b1, 2'b01), 3'd2);
        step("sw_decode", SW_OP, 3'b000, 1'b0, 1'b1, S_DECODE, o_dec(2'b01, 1'b0), 3'd2);
        step("sw_memadr", SW_OP, 3'b000, 1'b0, 1'b1, S_MEMADR,
             o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'b01, 0), 3'd2);
        step("sw_memwrite_wait", SW_OP, 3'b000, 1'b0, 1'b0, S_MEMWRITE,
             o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0), 3'd2);
        step("sw_memwrite_done", SW_OP, 3'b000, 1'b0, 1'b1, S_MEMWRITE,
             o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0), 3'd2);

        // branches: beq taken, beq not taken, bne taken
        cnt = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("br%0d_fetch", i), BR_OP, br_tab[i].f3, br_tab[i].z, 1'b1, S_FETCH,
                 o_fetch(1'b1, 2'b10), cnt);
            step($sformatf("br%0d_decode", i), BR_OP, br_tab[i].f3, br_tab[i].z, 1'b1, S_DECODE,
                 o_dec(2'b10, 1'b0), cnt);
            step($sformatf("br%0d_branch", i), BR_OP, br_tab[i].f3, br_tab[i].z, 1'b1, S_BRANCH,
                 o(br_tab[i].pc, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 2'b10, 0), cnt);
            cnt = cnt + 3'd1;
        end

        // illegal opcode: one-cycle pulse, back to FETCH, not counted
        step("ill_fetch", BAD_OP, 3'b000, 1'b0, 1'b1, S_FETCH, o_fetch(1'b1, 2'b00), 3'd6);
        step("ill_decode", BAD_OP, 3'b000, 1'b0, 1'b1, S_DECODE, o_dec(2'b00, 1'b1), 3'd6);

        // jal, then I-type wraps the counter 7 -> 0
        step("jal_fetch_after_ill", JAL_OP, 3'b000, 1'b0, 1'b1, S_FETCH, o_fetch(1'b1, 2'b11), 3'd6);
        step("jal_decode", JAL_OP, 3'b000, 1'b0, 1'b1, S_DECODE, o_dec(2'b11, 1'b0), 3'd6);
        step("jal_jal", JAL_OP, 3'b000, 1'b0, 1'b1, S_JAL,
             o(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b11, 0), 3'd6);
        step("jal_aluwb", JAL_OP, 3'b000, 1'b0, 1'b1, S_ALUWB,
             o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b11, 0), 3'd6);
        step("i_fetch", I_OP, 3'b000, 1'b0, 1'b1, S_FETCH, o_fetch(1'b1, 2'b00), 3'd7);
        step("i_decode", I_OP, 3'b000, 1'b0, 1'b1, S_DECODE, o_dec(2'b00, 1'b0), 3'd7);
        step("i_execi", I_OP, 3'b000, 1'b0, 1'b1, S_EXECI,
             o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 2'b00, 0), 3'd7);
        step("i_aluwb", I_OP, 3'b000, 1'b0, 1'b1, S_ALUWB,
             o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0), 3'd7);
        step("wrap_r_fetch", R_OP, 3'b000, 1'b0, 1'b1, S_FETCH, o_fetch(1'b1, 2'b00), 3'd0);
        step("wrap_r_decode", R_OP, 3'b000, 1'b0, 1'b1, S_DECODE, o_dec(2'b00, 1'b0), 3'd0);
        step("wrap_r_execr", R_OP, 3'b000, 1'b0, 1'b1, S_EXECR,
             o(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 2'b00, 0), 3'd0);
        step("wrap_r_aluwb", R_OP, 3'b000, 1'b0, 1'b1, S_ALUWB,
             o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0), 3'd0);

        // sw interrupted by reset while Mem_Write is high
        step("rsw_fetch", SW_OP, 3'b000, 1'b0, 1'b1, S_FETCH, o_fetch(1'b1, 2'b01), 3'd1);
        step("rsw_decode", SW_OP, 3'b000, 1'b0, 1'b1, S_DECODE, o_dec(2'b01, 1'b0), 3'd1);
        step("rsw_memadr", SW_OP, 3'b000, 1'b0, 1'b1, S_MEMADR,
             o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'b01, 0), 3'd1);
        Mem_Ready = 1'b0;
        push_exp("rsw_memwrite", S_MEMWRITE,
                 o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0), 3'd1);
        @(negedge clk);
        #3;
        Op = R_OP;
        push_exp("rsw_async_reset", S_RST, 16'h0000, 3'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step("rsw_reset_hold", R_OP, 3'b000, 1'b0, 1'b1, S_RST, 16'h0000, 3'd0);
        rst_n = 1'b1;
        step("rsw_reset_release", R_OP, 3'b000, 1'b0, 1'b1, S_RST, 16'h0000, 3'd0);
        step("rsw_restart_fetch", R_OP, 3'b000, 1'b0, 1'b1, S_FETCH, o_fetch(1'b1, 2'b00), 3'd0);

        repeat (3) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle control FSM of the RISC-V multicycle core. It sequences fetch, decode, execute, memory and writeback per instruction.
- It is the producer of the 2-bit Alu_Op code that the ALU decoder consumes, and it drives all datapath mux selects and enables.
- Supports lw, sw, R-type, I-type ALU, jal, beq/bne, with a memory-ready handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Op  in  7  instruction opcode bits [6:0] from the instruction register.
- Funct3  in  3  instruction bits [14:12]; only bit 0 is used, in branch resolution.
- Zero  in  1  ALU zero flag.
- Mem_Ready  in  1  memory access completes this cycle.
- Pc_Write  out  1  PC register enable.
- Adr_Src  out  1  memory address select: 0 = PC, 1 = Result.
- Mem_Write  out  1  data memory write enable.
- Ir_Write  out  1  instruction register / OldPC enable.
- Result_Src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- Alu_Src_A  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = RD1.
- Alu_Src_B  out  2  ALU operand B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- Reg_Write  out  1  register file write enable.
- Alu_Op  out  2  00 = add, 01 = subtract (branch), 10 = decode from funct fields.
- Imm_Src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- Illegal_Instr  out  1  one-cycle pulse on an unsupported opcode.
- Instr_Count  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst_n = 0, asynchronous): state = RST; Instr_Count = 0; every output is 0. RST moves to FETCH on the first clock edge after release.
- Outputs are Moore, decoded from the state, except two qualifications: Mem_Ready gates the FETCH enables, and Zero/Funct3 gate Pc_Write in BRANCH.
- Outputs not listed for a state are 0.
- Imm_Src is combinational from Op in every state: lw/I-ALU → 00, sw → 01, branch → 10, jal → 11, else 00.
- FETCH:
  - Outputs: Adr_Src = 0, Alu_Src_A = 00, Alu_Src_B = 10, Alu_Op = 00, Result_Src = 10.
  - Ir_Write and Pc_Write equal Mem_Ready. Stay in FETCH while Mem_Ready = 0; go to DECODE when Mem_Ready = 1.
- DECODE:
  - Outputs: Alu_Src_A = 01, Alu_Src_B = 01, Alu_Op = 00 (branch target).
  - Next state by Op: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1101111 → JAL; 1100011 → BRANCH.
  - Any other Op → FETCH, with Illegal_Instr = 1 for this cycle. Illegal instructions are not counted.
- MEMADR: Alu_Src_A = 10, Alu_Src_B = 01, Alu_Op = 00. Op[5] = 0 → MEMREAD; Op[5] = 1 → MEMWRITE.
- MEMREAD: Result_Src = 00, Adr_Src = 1. Hold until Mem_Ready = 1, then → MEMWB.
- MEMWB: Result_Src = 01, Reg_Write = 1 → FETCH (retire).
- MEMWRITE: Result_Src = 00, Adr_Src = 1, Mem_Write = 1. Mem_Write stays high until Mem_Ready = 1, then → FETCH (retire).
- EXECR: Alu_Src_A = 10, Alu_Src_B = 00, Alu_Op = 10 → ALUWB.
- EXECI: Alu_Src_A = 10, Alu_Src_B = 01, Alu_Op = 10 → ALUWB.
- JAL: Alu_Src_A = 01, Alu_Src_B = 10, Alu_Op = 00, Result_Src = 00, Pc_Write = 1 → ALUWB.
- ALUWB: Result_Src = 00, Reg_Write = 1 → FETCH (retire).
- BRANCH:
  - Outputs: Alu_Src_A = 10, Alu_Src_B = 00, Alu_Op = 01, Result_Src = 00.
  - Pc_Write = Zero XOR Funct3[0] (beq taken on Zero = 1, bne taken on Zero = 0) → FETCH (retire).
- Retire: Instr_Count increments by 1 on the clock edge leaving MEMWB, MEMWRITE (with Mem_Ready = 1), ALUWB or BRANCH. It wraps from all-ones to 0.
- Latency in clocks, with Mem_Ready always 1: lw 5, sw 4, R/I 4, jal 4, branch 3.
- Reset mid-instruction: the FSM returns to RST immediately. No partial Mem_Write or Reg_Write pulse may survive the reset edge.
- Unreachable state encodings → FETCH on the next clock, with no outputs asserted.

Decomposition:
- Package core_ctrl_pkg holds:
  - the state enum: RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH (4-bit encoding);
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR;
  - Alu_Op, Result_Src, Alu_Src_A and Alu_Src_B encodings.
- Natural sub-module: instr_dec_imm, the combinational Op → Imm_Src decoder. The FSM and counter stay in main_fsm.

Test Plan:
- Reset, then release with Op = 0110011 and Mem_Ready = 1:
  - all outputs 0 while in reset;
  - state sequence FETCH, DECODE, EXECR, ALUWB;
  - Alu_Op = 10 in EXECR; Reg_Write = 1 in ALUWB; Instr_Count = 1.
- lw (Op = 0000011) with Mem_Ready held 0 for 3 cycles in MEMREAD:
  - MEMREAD lasts 4 cycles with Adr_Src = 1 throughout;
  - MEMWB follows with Result_Src = 01 and Reg_Write = 1.
- sw (Op = 0100011): Mem_Write = 1 for exactly the MEMWRITE cycles up to and including the Mem_Ready = 1 cycle; Reg_Write never asserted.
- Branch (Op = 1100011) in BRANCH: Alu_Op = 01 and Pc_Write follows Zero XOR Funct3[0]:
  - Funct3 = 000, Zero = 1 → Pc_Write = 1;
  - Funct3 = 000, Zero = 0 → Pc_Write = 0;
  - Funct3 = 001, Zero = 0 → Pc_Write = 1.
- Op = 1111111 in DECODE → Illegal_Instr pulses for 1 cycle, next state FETCH, Instr_Count unchanged.
- Assert rst_n = 0 mid-MEMWRITE → Mem_Write drops to 0 asynchronously, before the next clock edge. Preload the counter near all-ones and retire 2 instructions → Instr_Count wraps to 0.
